// File: rtl/mem_io_unit.sv
// Memory and I/O unit: 4 KB big-endian RAM plus a small MMIO block
// (free-running cycle counter, LED register, 4-entry transmit FIFO and
// a status register with sticky misalign/overflow flags).
//
// Transmit handshake: the unit presents txData with txValid high
// whenever the FIFO holds a byte; a byte is consumed on a rising clk
// edge where txValid and txReady are both high. txReady while empty
// is ignored.
module mem_io_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] memAddr,
   input  logic        MemWrite,
   input  logic [1:0]  MemMode,
   input  logic [31:0] writeMemData,
   output logic [31:0] memData,
   output logic [7:0]  ledOut,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady
);

   localparam logic [15:0] ADDR_CYCLE  = 16'hFF00;
   localparam logic [15:0] ADDR_LED    = 16'hFF04;
   localparam logic [15:0] ADDR_TXDATA = 16'hFF08;
   localparam logic [15:0] ADDR_STATUS = 16'hFF0C;

   localparam logic [2:0] FIFO_DEPTH = 3'd4;

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [31:0] ram_q [0:1023];

   logic [31:0] cycle_q,    cycle_d;
   logic [7:0]  led_q,      led_d;
   logic [7:0]  fifo_q [0:3];
   logic [7:0]  fifo_d [0:3];
   logic [1:0]  rd_ptr_q,   rd_ptr_d;
   logic [1:0]  wr_ptr_q,   wr_ptr_d;
   logic [2:0]  count_q,    count_d;
   logic        misalign_q, misalign_d;
   logic        overflow_q, overflow_d;

   // ---------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------
   logic        sel_ram;
   logic        sel_cycle;
   logic        sel_led;
   logic        sel_tx;
   logic        sel_status;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic [9:0]  ram_idx;
   logic [31:0] ram_word;
   logic [31:0] ram_wdata;
   logic        ram_we;

   assign sel_ram    = (memAddr[15:12] == 4'h0);
   assign sel_cycle  = (memAddr == ADDR_CYCLE);
   assign sel_led    = (memAddr == ADDR_LED);
   assign sel_tx     = (memAddr == ADDR_TXDATA);
   assign sel_status = (memAddr == ADDR_STATUS);

   // Mode 11 falls through to word access.
   assign is_byte = (MemMode == 2'b10);
   assign is_half = (MemMode == 2'b01);
   assign is_word = !is_byte && !is_half;

   // Alignment only matters for RAM; MMIO registers ignore it.
   assign misaligned = sel_ram &&
                       ((is_word && (memAddr[1:0] != 2'b00)) ||
                        (is_half && memAddr[0]));

   assign ram_idx  = memAddr[11:2];
   assign ram_word = ram_q[ram_idx];

   // A write held during reset is dropped; RAM content stays intact.
   assign ram_we = MemWrite && sel_ram && !misaligned && !reset;

   // ---------------------------------------------------------------
   // RAM write data: merge the selected big-endian lane into the word
   // ---------------------------------------------------------------
   always_comb begin
      ram_wdata = ram_word;
      if (is_byte) begin
         case (memAddr[1:0])
            2'd0:    ram_wdata[31:24] = writeMemData[7:0];
            2'd1:    ram_wdata[23:16] = writeMemData[7:0];
            2'd2:    ram_wdata[15:8]  = writeMemData[7:0];
            default: ram_wdata[7:0]   = writeMemData[7:0];
         endcase
      end else if (is_half) begin
         if (memAddr[1]) begin
            ram_wdata[15:0] = writeMemData[15:0];
         end else begin
            ram_wdata[31:16] = writeMemData[15:0];
         end
      end else begin
         ram_wdata = writeMemData;
      end
   end

   // RAM array: no reset, contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= ram_wdata;
      end
   end

   // ---------------------------------------------------------------
   // Register / FIFO next-state logic
   // ---------------------------------------------------------------
   logic fifo_pop;
   logic fifo_push;
   logic push_ok;
   logic ovf_set;
   logic mis_set;
   logic flag_clear;

   assign fifo_pop   = txReady && (count_q != 3'd0);
   assign fifo_push  = MemWrite && sel_tx;
   // A pop in the same edge frees the slot, so a push onto a full FIFO
   // is only lost when nothing leaves.
   assign push_ok    = fifo_push && ((count_q != FIFO_DEPTH) || fifo_pop);
   assign ovf_set    = fifo_push && (count_q == FIFO_DEPTH) && !fifo_pop;
   assign mis_set    = MemWrite && misaligned;
   assign flag_clear = MemWrite && sel_status;

   // Next-state for counter, LED, FIFO and sticky flags.
   always_comb begin
      cycle_d    = cycle_q + 32'd1;
      led_d      = led_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      for (int i = 0; i < 4; i++) begin
         fifo_d[i] = fifo_q[i];
      end

      if (MemWrite && sel_led) begin
         led_d = writeMemData[7:0];
      end

      if (push_ok) begin
         fifo_d[wr_ptr_q] = writeMemData[7:0];
         wr_ptr_d         = wr_ptr_q + 2'd1;
      end
      if (fifo_pop) begin
         rd_ptr_d = rd_ptr_q + 2'd1;
      end
      count_d = count_q + {2'b00, push_ok} - {2'b00, fifo_pop};

      // Set events take priority over a same-cycle clear.
      misalign_d = mis_set || (misalign_q && !flag_clear);
      overflow_d = ovf_set || (overflow_q && !flag_clear);
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q    <= 32'd0;
         led_q      <= 8'd0;
         rd_ptr_q   <= 2'd0;
         wr_ptr_q   <= 2'd0;
         count_q    <= 3'd0;
         misalign_q <= 1'b0;
         overflow_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            fifo_q[i] <= 8'd0;
         end
      end else begin
         cycle_q    <= cycle_d;
         led_q      <= led_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         misalign_q <= misalign_d;
         overflow_q <= overflow_d;
         for (int i = 0; i < 4; i++) begin
            fifo_q[i] <= fifo_d[i];
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   logic fifo_empty;
   logic fifo_full;

   assign fifo_empty = (count_q == 3'd0);
   assign fifo_full  = (count_q == FIFO_DEPTH);

   assign ledOut  = led_q;
   assign txValid = !fifo_empty;
   assign txData  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

   // Load data mux: RAM lanes zero-extended, MMIO full width.
   always_comb begin
      memData = 32'd0;
      if (sel_ram) begin
         if (!misaligned) begin
            if (is_byte) begin
               case (memAddr[1:0])
                  2'd0:    memData = {24'd0, ram_word[31:24]};
                  2'd1:    memData = {24'd0, ram_word[23:16]};
                  2'd2:    memData = {24'd0, ram_word[15:8]};
                  default: memData = {24'd0, ram_word[7:0]};
               endcase
            end else if (is_half) begin
               memData = memAddr[1] ? {16'd0, ram_word[15:0]}
                                    : {16'd0, ram_word[31:16]};
            end else begin
               memData = ram_word;
            end
         end
      end else if (sel_cycle) begin
         memData = cycle_q;
      end else if (sel_led) begin
         memData = {24'd0, led_q};
      end else if (sel_status) begin
         memData = {25'd0, overflow_q, misalign_q, fifo_full, fifo_empty,
                    count_q};
      end
   end

endmodule

// File: tb/tb_mem_io_unit.sv
// Bench for mem_io_unit: byte-array / queue reference model, scoreboard
// queues for load data and the transmit stream, directed scenarios then
// randomized traffic.
module tb_mem_io_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] mem_addr;
   logic        mem_write;
   logic [1:0]  mem_mode;
   logic [31:0] wdata;
   logic [31:0] mem_data;
   logic [7:0]  led_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        rd_req;

   int total = 0;
   int bad   = 0;

   logic [31:0] rd_exp_q[$];
   logic [7:0]  tx_exp_q[$];

   // reference model state
   logic [7:0]  mem_m [0:4095];
   logic [31:0] cyc_m;
   logic [7:0]  led_m;
   logic [7:0]  fifo_m[$];
   logic        mis_m;
   logic        ovf_m;
   logic        pop_m;

   mem_io_unit dut (
      .clk          (clk),
      .reset        (reset),
      .memAddr      (mem_addr),
      .MemWrite     (mem_write),
      .MemMode      (mem_mode),
      .writeMemData (wdata),
      .memData      (mem_data),
      .ledOut       (led_out),
      .txData       (tx_data),
      .txValid      (tx_valid),
      .txReady      (tx_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_misaligned(input logic [15:0] a, input logic [1:0] m);
      if (a >= 16'h1000) return 1'b0;
      if (m == 2'b10) return 1'b0;
      if (m == 2'b01) return a[0];
      return (a[1:0] != 2'b00);
   endfunction

   function automatic logic [31:0] model_read(input logic [15:0] a, input logic [1:0] m);
      int b;
      b = int'(a);
      if (a < 16'h1000) begin
         if (model_misaligned(a, m)) return 32'd0;
         if (m == 2'b10) return {24'd0, mem_m[b]};
         if (m == 2'b01) return {16'd0, mem_m[b], mem_m[b+1]};
         return {mem_m[b], mem_m[b+1], mem_m[b+2], mem_m[b+3]};
      end
      case (a)
         16'hFF00: return cyc_m;
         16'hFF04: return {24'd0, led_m};
         16'hFF0C: return {25'd0, ovf_m, mis_m, fifo_m.size() == 4,
                           fifo_m.size() == 0, 3'(fifo_m.size())};
         default:  return 32'd0;
      endcase
   endfunction

   // ---------------- reference model ----------------
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_m = 32'd0;
         led_m = 8'd0;
         fifo_m.delete();
         tx_exp_q.delete();
         mis_m = 1'b0;
         ovf_m = 1'b0;
      end else begin
         cyc_m = cyc_m + 32'd1;
         pop_m = tx_ready && (fifo_m.size() > 0);
         if (pop_m) void'(fifo_m.pop_front());
         if (mem_write) begin
            if (mem_addr < 16'h1000) begin
               if (model_misaligned(mem_addr, mem_mode)) begin
                  mis_m = 1'b1;
               end else if (mem_mode == 2'b10) begin
                  mem_m[int'(mem_addr)] = wdata[7:0];
               end else if (mem_mode == 2'b01) begin
                  mem_m[int'(mem_addr)]     = wdata[15:8];
                  mem_m[int'(mem_addr) + 1] = wdata[7:0];
               end else begin
                  mem_m[int'(mem_addr)]     = wdata[31:24];
                  mem_m[int'(mem_addr) + 1] = wdata[23:16];
                  mem_m[int'(mem_addr) + 2] = wdata[15:8];
                  mem_m[int'(mem_addr) + 3] = wdata[7:0];
               end
            end else if (mem_addr == 16'hFF04) begin
               led_m = wdata[7:0];
            end else if (mem_addr == 16'hFF08) begin
               if (fifo_m.size() < 4) begin
                  fifo_m.push_back(wdata[7:0]);
                  tx_exp_q.push_back(wdata[7:0]);
               end else begin
                  ovf_m = 1'b1;
               end
            end else if (mem_addr == 16'hFF0C) begin
               mis_m = 1'b0;
               ovf_m = 1'b0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!reset) begin
         if (rd_req) begin
            if (rd_exp_q.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
            else check("mem_data", mem_data, rd_exp_q.pop_front());
         end
         check("tx_valid", 32'(tx_valid), 32'(fifo_m.size() != 0));
         check("tx_data", 32'(tx_data), (fifo_m.size() != 0) ? 32'(fifo_m[0]) : 32'd0);
         check("led_out", 32'(led_out), 32'(led_m));
         if (tx_valid && tx_ready) begin
            if (tx_exp_q.size() == 0) check("tx_stream_extra", 32'(tx_data), 32'hFFFF_FFFF);
            else check("tx_stream", 32'(tx_data), 32'(tx_exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [15:0] a, input logic [1:0] m, input logic we,
                        input logic [31:0] d, input logic rd, input logic rdy);
      @(posedge clk);
      #1;
      mem_addr  = a;
      mem_mode  = m;
      mem_write = we;
      wdata     = d;
      rd_req    = rd;
      tx_ready  = rdy;
   endtask

   task automatic do_write(input logic [15:0] a, input logic [1:0] m,
                           input logic [31:0] d, input logic rdy);
      drive(a, m, 1'b1, d, 1'b0, rdy);
   endtask

   task automatic do_read(input logic [15:0] a, input logic [1:0] m, input logic rdy);
      drive(a, m, 1'b0, 32'd0, 1'b1, rdy);
      rd_exp_q.push_back(model_read(a, m));
   endtask

   task automatic do_read_exp(input logic [15:0] a, input logic [1:0] m,
                              input logic [31:0] exp, input logic rdy);
      drive(a, m, 1'b0, 32'd0, 1'b1, rdy);
      rd_exp_q.push_back(exp);
   endtask

   task automatic idle(input logic rdy);
      drive(16'h0000, 2'b00, 1'b0, 32'd0, 1'b0, rdy);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      mem_addr  = 16'hFF00;
      mem_mode  = 2'b00;
      mem_write = 1'b0;
      wdata     = 32'd0;
      rd_req    = 1'b0;
      tx_ready  = 1'b0;
      #3;
      check("reset_led", 32'(led_out), 32'd0);
      check("reset_txvalid", 32'(tx_valid), 32'd0);
      check("reset_txdata", 32'(tx_data), 32'd0);
      check("reset_cycle", mem_data, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      do_read_exp(16'hFF00, 2'b00, 32'd1, 1'b0);

      // preload the RAM window used by random traffic
      for (int i = 0; i < 16; i++) do_write(16'(i * 4), 2'b00, $urandom, 1'b0);

      // word / lane reads
      do_write(16'h0010, 2'b00, 32'h1122_3344, 1'b0);
      do_read_exp(16'h0011, 2'b10, 32'h0000_0022, 1'b0);
      do_read_exp(16'h0012, 2'b01, 32'h0000_3344, 1'b0);
      do_read_exp(16'h0010, 2'b00, 32'h1122_3344, 1'b0);
      do_read_exp(16'h0010, 2'b11, 32'h1122_3344, 1'b0);

      // byte write, misaligned halfword write, status clear
      do_write(16'h0013, 2'b10, 32'h0000_00AB, 1'b0);
      do_read_exp(16'h0010, 2'b00, 32'h1122_33AB, 1'b0);
      do_write(16'h0011, 2'b01, 32'h0000_BEEF, 1'b0);
      do_read_exp(16'h0010, 2'b00, 32'h1122_33AB, 1'b0);
      do_read_exp(16'h0011, 2'b00, 32'h0000_0000, 1'b0);
      do_read_exp(16'hFF0C, 2'b00, 32'h0000_0028, 1'b0);
      do_write(16'hFF0C, 2'b00, 32'h1234_5678, 1'b0);
      do_read_exp(16'hFF0C, 2'b00, 32'h0000_0008, 1'b0);

      // FIFO fill past full, then drain
      for (int i = 1; i <= 5; i++) do_write(16'hFF08, 2'b00, 32'(i), 1'b0);
      do_read_exp(16'hFF0C, 2'b00, 32'h0000_0054, 1'b0);
      do_read_exp(16'hFF08, 2'b00, 32'h0000_0000, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      do_read_exp(16'hFF0C, 2'b00, 32'h0000_0048, 1'b0);
      do_write(16'hFF0C, 2'b00, 32'd0, 1'b0);

      // push onto full FIFO with a simultaneous pop
      for (int i = 5; i <= 8; i++) do_write(16'hFF08, 2'b00, 32'(i), 1'b0);
      do_write(16'hFF08, 2'b00, 32'h0000_0009, 1'b1);
      do_read_exp(16'hFF0C, 2'b00, 32'h0000_0014, 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1);

      // LED, unmapped, async reset mid-write
      do_write(16'hFF04, 2'b10, 32'h0000_01A5, 1'b0);
      do_read_exp(16'hFF04, 2'b00, 32'h0000_00A5, 1'b0);
      do_write(16'h2000, 2'b00, 32'hDEAD_BEEF, 1'b0);
      do_read_exp(16'h2000, 2'b00, 32'h0000_0000, 1'b0);
      do_write(16'hFF08, 2'b00, 32'h0000_0077, 1'b0);
      do_write(16'hFF04, 2'b00, 32'h0000_0033, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check("async_led", 32'(led_out), 32'd0);
      check("async_txvalid", 32'(tx_valid), 32'd0);
      check("async_txdata", 32'(tx_data), 32'd0);
      mem_addr = 16'hFF00;
      #1;
      check("async_cycle", mem_data, 32'd0);
      @(posedge clk);
      #1;
      mem_write = 1'b0;
      mem_addr  = 16'h0000;
      reset     = 1'b0;
      do_read_exp(16'hFF00, 2'b00, 32'd1, 1'b0);
      do_read_exp(16'hFF04, 2'b00, 32'd0, 1'b0);
      do_read_exp(16'h0010, 2'b00, 32'h1122_33AB, 1'b0);

      // randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int op;
         logic rdy;
         logic [15:0] ra;
         op  = $urandom_range(0, 9);
         rdy = 1'($urandom_range(0, 1));
         ra  = 16'($urandom_range(0, 63));
         case (op)
            0, 1: do_write(ra, 2'($urandom_range(0, 3)), $urandom, rdy);
            2, 3: do_read(ra, 2'($urandom_range(0, 3)), rdy);
            4:    do_write(16'hFF08, 2'($urandom_range(0, 3)), $urandom, rdy);
            5:    do_read(16'hFF0C, 2'($urandom_range(0, 3)), rdy);
            6:    if ($urandom_range(0, 3) == 0) do_write(16'hFF0C, 2'b00, $urandom, rdy);
                  else do_write(16'hFF04, 2'b00, $urandom, rdy);
            7:    do_read(16'hFF00, 2'b00, rdy);
            8:    do_read(16'($urandom_range(16'h1000, 16'hFEFF)), 2'b00, rdy);
            default: idle(rdy);
         endcase
      end

      // bounded drain of the transmit stream
      for (int i = 0; i < 10 && tx_exp_q.size() > 0; i++) idle(1'b1);
      idle(1'b0);
      idle(1'b0);
      check("tx_drain_left", 32'(tx_exp_q.size()), 32'd0);
      check("rd_left", 32'(rd_exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
